riscv_prefetch_buffer_ot: RTL and testbench
===========================================

// Module: riscv_prefetch_buffer_ot
// PURPOSE
// - Parametrised instruction prefetcher between the IF stage and instruction memory/cache.
// - Keeps up to MAX_OT requests in flight and buffers returned words in a DEPTH-entry FIFO.
// - Carries a TAG_W-bit DIFT tag per word.
// - On branch: flushes the FIFO in the branch cycle and silently drops stale responses.
// PARAMETERS
// DEPTH   4  FIFO entries (power of 2, >=2)
// MAX_OT  2  max outstanding granted-but-not-returned requests (1..DEPTH)
// TAG_W   4  DIFT tag width per 32-bit word (>=1)
// PORTS
// clk             in   1      clock
// rst_n           in   1      async active-low reset
// req_i           in   1      fetching enabled
// branch_i        in   1      redirect, 1-cycle pulse
// branch_addr_i   in   32     redirect target; bits[1:0] ignored
// fetch_ready_i   in   1      consumer accepts head word
// fetch_valid_o   out  1      head word valid
// fetch_rdata_o   out  32     head word data
// fetch_rtag_o    out  TAG_W  head word DIFT tag
// fetch_addr_o    out  32     head word address, word-aligned
// fetch_err_o     out  1      head word fetch faulted (PMP/bus)
// instr_req_o     out  1      memory request
// instr_gnt_i     in   1      memory grant
// instr_addr_o    out  32     memory address, word-aligned
// instr_rvalid_i  in   1      response valid
// instr_rdata_i   in   32     response data
// instr_rtag_i    in   TAG_W  response tag
// instr_err_i     in   1      response error, qualified by rvalid
// busy_o          out  1      ot_cnt!=0 | instr_req_o | drop_cnt!=0
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty; next_addr_q=0; ot_cnt=drop_cnt=0; FSM=RUN.
// - Counters: ot_cnt = live outstanding; drop_cnt = stale outstanding;
//   ot_cnt + drop_cnt <= MAX_OT at all times.
// - Issue rule: instr_req_o = req_i & FSM!=ERR_HALT & (ot_cnt+drop_cnt)<MAX_OT
//   & (fifo_cnt+ot_cnt)<DEPTH. Credit check uses registered counts; no pop lookahead.
// - Branch overrides ERR_HALT.
// - Address: instr_addr_o = branch_i ? {branch_addr_i[31:2],2'b00} : next_addr_q.
// - Grant: on req&gnt, push instr_addr_o into an MAX_OT-deep address queue;
//   next_addr_q <= instr_addr_o+4; ot_cnt++. Wrap at 2^32 is silent.
// - instr_req_o/instr_addr_o may change while ungranted only on branch_i.
// - Response ordering: in order; rvalid no earlier than the cycle after gnt.
// - Response handling:
//   * drop_cnt>0: rvalid decrements drop_cnt; word discarded.
//   * Otherwise: ot_cnt--; push {rdata,rtag,err,addr from address queue} into FIFO.
//   * Credit rule guarantees the FIFO never overflows.
// - Output: head word combinational from FIFO; pop on fetch_valid_o & fetch_ready_i.
//   Latency gnt->fetch_valid_o = rvalid cycle +1 (FIFO registered).
// - Same-cycle gnt and rvalid: ot_cnt unchanged. Same-cycle push and pop allowed, incl. full.
// - Branch cycle:
//   * FIFO cleared; pop ignored.
//   * drop_cnt <= drop_cnt + ot_cnt - (live rvalid this cycle); rvalid this cycle dropped.
//   * Address queue cleared.
//   * A request granted in the branch cycle is live (ot_cnt=1).
//   * FSM -> RUN.
// - FSM:
//   * RUN -> ERR_HALT when a live word with instr_err_i=1 is pushed; it is still pushed.
//   * ERR_HALT: no new requests. Responses already outstanding still return and are pushed.
//   * ERR_HALT -> RUN only on branch_i.
// - req_i=0: no new requests; outstanding responses still complete.
// - Async reset mid-transaction: all state cleared. The memory side must also be reset.
// TESTING
// - Stream, gnt=1, rvalid 1 cycle after gnt, ready=1, branch to 0x100 -> fetch_addr_o
//   0x100,0x104,0x108... one word/cycle; ot_cnt never >MAX_OT=2.
// - ready=0 -> exactly DEPTH=4 words buffered, instr_req_o=0.
//   Then ready=1 -> in-order drain, fetching resumes.
// - Branch to 0x200 with 2 outstanding (0x108,0x10C) -> both responses dropped,
//   drop_cnt 2->0, first word out is 0x200.
// - Branch in the same cycle as an rvalid -> returning word dropped;
//   branch target 0x302 gives instr_addr_o=0x300.
// - Error on word 0x40C -> fetch_err_o=1 at 0x40C, no further instr_req_o.
//   Later branch 0x500 -> resumes at 0x500.
// - gnt delayed 3 cycles -> instr_addr_o stable 0x600 until gnt; no duplicate FIFO entries.

Source files
------------

// File: rtl/riscv_prefetch_buffer_ot_if.sv
// Bus bundle between the prefetcher, the IF-stage consumer and instruction memory.
// The master modport is the prefetcher side; slave is the consumer/memory side.
interface riscv_prefetch_buffer_ot_if #(
  parameter int unsigned TAG_W = 4
) ();
  logic             fetch_valid_o;
  logic [31:0]      fetch_rdata_o;
  logic [TAG_W-1:0] fetch_rtag_o;
  logic [31:0]      fetch_addr_o;
  logic             fetch_err_o;
  logic             fetch_ready_i;

  logic             instr_req_o;
  logic [31:0]      instr_addr_o;
  logic             instr_gnt_i;
  logic             instr_rvalid_i;
  logic [31:0]      instr_rdata_i;
  logic [TAG_W-1:0] instr_rtag_i;
  logic             instr_err_i;

  modport master (
    output fetch_valid_o, fetch_rdata_o, fetch_rtag_o, fetch_addr_o, fetch_err_o,
    input  fetch_ready_i,
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_rtag_i, instr_err_i
  );

  modport slave (
    input  fetch_valid_o, fetch_rdata_o, fetch_rtag_o, fetch_addr_o, fetch_err_o,
    output fetch_ready_i,
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_rtag_i, instr_err_i
  );
endinterface

// File: rtl/riscv_prefetch_buffer_ot.sv
// Instruction prefetcher: up to MAX_OT requests in flight, DEPTH-entry response FIFO,
// per-word DIFT tag, branch flush with silent dropping of stale responses.
module riscv_prefetch_buffer_ot #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MAX_OT = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_i,
  input  logic                       branch_i,
  input  logic [31:0]                branch_addr_i,
  output logic                       busy_o,
  riscv_prefetch_buffer_ot_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned AqW  = (MAX_OT > 1) ? $clog2(MAX_OT) : 1;
  localparam logic [CntW:0]  MaxOt  = (CntW + 1)'(MAX_OT);
  localparam logic [CntW:0]  Depth  = (CntW + 1)'(DEPTH);
  localparam logic [AqW-1:0] AqLast = AqW'(MAX_OT - 1);

  typedef enum logic [0:0] {StRun, StErrHalt} state_e;

  state_e          state_q;
  logic [31:0]     next_addr_q, next_addr_d;
  logic [CntW-1:0] ot_q, ot_d, drop_q, drop_d, fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [AqW-1:0]  aq_wptr_q, aq_rptr_q, aq_wbase;

  logic [31:0]      fifo_data_q [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q  [DEPTH];
  logic             fifo_err_q  [DEPTH];
  logic [31:0]      fifo_addr_q [DEPTH];
  logic [31:0]      aq_q        [MAX_OT];

  logic            issue, gnt_fire, stale, live_rv, push, pop;
  logic [CntW:0]   in_flight, credit;
  logic [31:0]     target, addr_out;
  logic            unused_addr_bits;

  function automatic logic [AqW-1:0] aq_inc(input logic [AqW-1:0] p);
    return (p == AqLast) ? '0 : p + 1'b1;
  endfunction

  assign target           = {branch_addr_i[31:2], 2'b00};
  assign unused_addr_bits = ^branch_addr_i[1:0];

  // Credits use registered counts only; a pop this cycle does not free a slot until next cycle.
  assign in_flight = {1'b0, ot_q} + {1'b0, drop_q};
  assign credit    = {1'b0, fifo_cnt_q} + {1'b0, ot_q};
  assign issue     = req_i & ((state_q == StRun) | branch_i) & (in_flight < MaxOt) &
                     (credit < Depth);
  assign gnt_fire  = issue & bus.instr_gnt_i;
  assign addr_out  = branch_i ? target : next_addr_q;

  assign stale    = (drop_q != '0);
  assign live_rv  = bus.instr_rvalid_i & ~stale & ~branch_i;
  assign push     = live_rv;
  assign pop      = bus.fetch_valid_o & bus.fetch_ready_i & ~branch_i;
  assign aq_wbase = branch_i ? '0 : aq_wptr_q;

  assign bus.instr_req_o   = issue;
  assign bus.instr_addr_o  = addr_out;
  assign bus.fetch_valid_o = (fifo_cnt_q != '0);
  assign bus.fetch_rdata_o = fifo_data_q[rptr_q];
  assign bus.fetch_rtag_o  = fifo_tag_q[rptr_q];
  assign bus.fetch_err_o   = fifo_err_q[rptr_q];
  assign bus.fetch_addr_o  = fifo_addr_q[rptr_q];
  assign busy_o            = (ot_q != '0) | issue | stale;

  always_comb begin
    next_addr_d = next_addr_q;
    if (gnt_fire) begin
      next_addr_d = addr_out + 32'd4;
    end else if (branch_i) begin
      next_addr_d = target;
    end
    if (branch_i) begin
      // Everything outstanding becomes stale; a response arriving now is already discarded.
      ot_d       = CntW'(gnt_fire);
      drop_d     = in_flight[CntW-1:0] - CntW'(bus.instr_rvalid_i);
      fifo_cnt_d = '0;
    end else begin
      ot_d       = ot_q + CntW'(gnt_fire) - CntW'(live_rv);
      drop_d     = drop_q - CntW'(bus.instr_rvalid_i & stale);
      fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q <= '0;
      ot_q        <= '0;
      drop_q      <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      next_addr_q <= next_addr_d;
      ot_q        <= ot_d;
      drop_q      <= drop_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:     if (!branch_i && push && bus.instr_err_i) state_q <= StErrHalt;
        StErrHalt: if (branch_i) state_q <= StRun;
        default:   state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
        fifo_err_q[i]  <= 1'b0;
        fifo_addr_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wptr_q] <= bus.instr_rdata_i;
        fifo_tag_q[wptr_q]  <= bus.instr_rtag_i;
        fifo_err_q[wptr_q]  <= bus.instr_err_i;
        fifo_addr_q[wptr_q] <= aq_q[aq_rptr_q];
      end
      if (branch_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Address queue holds only live requests; stale ones are forgotten on branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_OT; i++) aq_q[i] <= '0;
      aq_wptr_q <= '0;
      aq_rptr_q <= '0;
    end else begin
      if (gnt_fire) begin
        aq_q[aq_wbase] <= addr_out;
        aq_wptr_q      <= aq_inc(aq_wbase);
      end else begin
        aq_wptr_q      <= aq_wbase;
      end
      if (branch_i) begin
        aq_rptr_q <= '0;
      end else if (push) begin
        aq_rptr_q <= aq_inc(aq_rptr_q);
      end
    end
  end

endmodule

// File: tb/tb_riscv_prefetch_buffer_ot.sv
// Randomised bench for riscv_prefetch_buffer_ot against a memory model and an
// address-stream reference (consumer sees target, target+4, ... after every redirect).
module tb_riscv_prefetch_buffer_ot;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAX_OT = 2;
  localparam int unsigned TAG_W  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        busy_o;

  riscv_prefetch_buffer_ot_if #(.TAG_W(TAG_W)) bus ();

  riscv_prefetch_buffer_ot #(.DEPTH(DEPTH), .MAX_OT(MAX_OT), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .branch_i     (branch_i),
    .branch_addr_i(branch_addr_i),
    .busy_o       (busy_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          gcyc;
  } txn_t;

  txn_t        pend[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  bit          halted = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] next_req = '0;
  int          pops = 0;
  int          drops = 0;
  bit          last_rv = 0;
  bit          prev_pend = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] err_seen_addr = '1;
  int          req_prob = 100;
  int          ready_prob = 100;
  int          gnt_mode = 1;
  int          gnt_prob = 100;
  int          gnt_delay = 0;
  int          wait_cnt = 0;
  int          rv_mode = 1;
  int          rv_prob = 100;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [TAG_W-1:0] mem_tag(input logic [31:0] a);
    return TAG_W'(a >> 2) ^ TAG_W'(a >> 7);
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == 32'h0000_040C) || ((a[31:16] == 16'h0001) && (a[6:2] == 5'h13));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, decide grant after addr settles, record effects.
  task automatic step(input bit br, input logic [31:0] tgt);
    logic [31:0] tgt_al;
    bit          rdy, rv, gnt, fire, live;
    txn_t        t;
    @(negedge clk);
    tgt_al        = {tgt[31:2], 2'b00};
    req_i         = ($urandom_range(99) < req_prob);
    branch_i      = br;
    branch_addr_i = br ? tgt : $urandom;
    rdy           = ($urandom_range(99) < ready_prob);
    bus.fetch_ready_i = rdy;
    rv = 1'b0;
    if (rv_mode != 0 && pend.size() > 0 && pend[0].gcyc < cyc)
      rv = (rv_mode == 1) || ($urandom_range(99) < rv_prob);
    bus.instr_rvalid_i = rv;
    if (rv) begin
      bus.instr_rdata_i = mem_data(pend[0].addr);
      bus.instr_rtag_i  = mem_tag(pend[0].addr);
      bus.instr_err_i   = mem_err(pend[0].addr);
    end else begin
      bus.instr_rdata_i = $urandom;
      bus.instr_rtag_i  = TAG_W'($urandom);
      bus.instr_err_i   = 1'($urandom_range(1));
    end
    bus.instr_gnt_i = 1'b0;
    #1;
    check_eq("instr_addr", bus.instr_addr_o, br ? tgt_al : next_req);
    if (halted && !br) check_eq("halt_noreq", 32'(bus.instr_req_o), 0);
    if (prev_pend && !br && req_i && !halted) begin
      check_eq("req_hold", 32'(bus.instr_req_o), 1);
      check_eq("addr_hold", bus.instr_addr_o, prev_addr);
    end
    case (gnt_mode)
      0:       gnt = 1'b0;
      1:       gnt = 1'b1;
      2:       gnt = ($urandom_range(99) < gnt_prob);
      default: begin
        gnt = 1'b0;
        if (bus.instr_req_o) begin
          if (wait_cnt >= gnt_delay) begin
            gnt = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    endcase
    bus.instr_gnt_i = gnt;
    #1;
    fire    = bus.instr_req_o && gnt;
    last_rv = rv;
    if (bus.fetch_valid_o && rdy && !br) begin
      pops++;
      check_eq("fetch_addr", bus.fetch_addr_o, exp_addr);
      check_eq("fetch_rdata", bus.fetch_rdata_o, mem_data(exp_addr));
      check_eq("fetch_rtag", 32'(bus.fetch_rtag_o), 32'(mem_tag(exp_addr)));
      check_eq("fetch_err", 32'(bus.fetch_err_o), 32'(mem_err(exp_addr)));
      if (bus.fetch_err_o) err_seen_addr = bus.fetch_addr_o;
      exp_addr = exp_addr + 32'd4;
    end
    if (rv) begin
      t    = pend.pop_front();
      live = !br && (t.epoch == epoch);
      if (live) begin
        if (mem_err(t.addr)) halted = 1'b1;
      end else begin
        drops++;
      end
    end
    if (br) begin
      epoch++;
      halted   = 1'b0;
      exp_addr = tgt_al;
      next_req = tgt_al;
    end
    if (fire) begin
      pend.push_back('{addr: bus.instr_addr_o, epoch: epoch, gcyc: cyc});
      next_req = bus.instr_addr_o + 32'd4;
      check_eq("ot_bound", 32'(pend.size() <= MAX_OT), 1);
    end
    prev_pend = bus.instr_req_o && !gnt;
    prev_addr = bus.instr_addr_o;
    cyc++;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    req_i = 1'b0;
    branch_i = 1'b0;
    bus.fetch_ready_i  = 1'b0;
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_err_i    = 1'b0;
    pend.delete();
    halted = 0;
    exp_addr = '0;
    next_req = '0;
    prev_pend = 0;
    wait_cnt = 0;
    #1;
    check_eq("rst_fetch_valid", 32'(bus.fetch_valid_o), 0);
    check_eq("rst_fetch_rdata", bus.fetch_rdata_o, 0);
    check_eq("rst_fetch_addr", bus.fetch_addr_o, 0);
    check_eq("rst_fetch_rtag", 32'(bus.fetch_rtag_o), 0);
    check_eq("rst_fetch_err", 32'(bus.fetch_err_o), 0);
    check_eq("rst_instr_req", 32'(bus.instr_req_o), 0);
    check_eq("rst_instr_addr", bus.instr_addr_o, 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0;
    logic [31:0] tgt;
    bit br;
    do_reset();

    // Streaming from 0x100: one word per cycle once the pipe is full.
    step(1'b1, 32'h100);
    repeat (3) step(1'b0, '0);
    p0 = pops;
    repeat (8) step(1'b0, '0);
    check_eq("stream_rate", p0 + 8, pops);

    // Consumer stalls: exactly DEPTH words buffer up and requesting stops.
    ready_prob = 0;
    repeat (12) step(1'b0, '0);
    check_eq("full_noreq", 32'(bus.instr_req_o), 0);
    check_eq("full_idle", 32'(busy_o), 0);
    ready_prob = 100;
    gnt_mode = 0;
    p0 = pops;
    repeat (8) step(1'b0, '0);
    check_eq("drain_cnt", pops - p0, DEPTH);
    gnt_mode = 1;
    p0 = pops;
    repeat (6) step(1'b0, '0);
    check_eq("resume_cnt", pops - p0, 4);

    // Redirect with two requests outstanding: both responses must vanish.
    rv_mode = 0;
    repeat (10) if (pend.size() < 2) step(1'b0, '0);
    check_eq("ot_two", pend.size(), 2);
    rv_mode = 1;
    d0 = drops;
    step(1'b1, 32'h200);
    repeat (6) step(1'b0, '0);
    check_eq("drop_two", drops - d0, 2);

    // Redirect coinciding with a response; unaligned target.
    repeat (3) step(1'b0, '0);
    d0 = drops;
    step(1'b1, 32'h302);
    check_eq("br_rv_same", 32'(last_rv), 1);
    repeat (4) step(1'b0, '0);
    check_eq("drop_same", drops - d0, 1);

    // Faulting word halts fetching until the next redirect.
    step(1'b1, 32'h400);
    repeat (12) step(1'b0, '0);
    check_eq("err_seen_addr", err_seen_addr, 32'h40C);
    check_eq("halt_req", 32'(bus.instr_req_o), 0);
    check_eq("halt_idle", 32'(busy_o), 0);
    p0 = pops;
    step(1'b1, 32'h500);
    repeat (6) step(1'b0, '0);
    check_eq("resume_500", pops - p0, 5);

    // Slow grant: request must stay put until accepted.
    gnt_mode = 3;
    gnt_delay = 3;
    wait_cnt = 0;
    p0 = pops;
    step(1'b1, 32'h600);
    repeat (20) step(1'b0, '0);
    check_eq("delay_progress", 32'((pops - p0) >= 3), 1);

    // Random traffic, with an asynchronous reset in the middle.
    gnt_mode = 2;
    gnt_prob = 70;
    rv_mode = 2;
    rv_prob = 60;
    ready_prob = 70;
    req_prob = 90;
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      br  = halted ? ($urandom_range(3) == 0) : ($urandom_range(99) < 3);
      tgt = ($urandom_range(1) ? 32'h0001_0000 : 32'h0002_0000) |
            (32'($urandom_range(1023)) << 2) | 32'($urandom_range(3));
      step(br, tgt);
    end
    check_eq("rand_progress", 32'((pops - p0) > 200), 1);

    // Quiesce: all outstanding responses return and the block goes idle.
    req_prob = 0;
    rv_mode = 1;
    gnt_mode = 1;
    ready_prob = 100;
    repeat (12) step(1'b0, '0);
    check_eq("final_pending", pend.size(), 0);
    check_eq("final_busy", 32'(busy_o), 0);
    check_eq("final_valid", 32'(bus.fetch_valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
